// File: rtl/tcdm_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// tcdm_stream_reader_pkg
// Shared types and constants for the strided TCDM stream reader.
//   rd_state_e    : reader FSM state encoding (IDLE, RUN, DRAIN)
//   AmoNone       : TCDM AMO opcode for a plain access
//   StallCntWidth : width of the request-stall performance counter
// -----------------------------------------------------------------------------
package tcdm_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    localparam logic [3:0]  AmoNone       = 4'h0;
    localparam int unsigned StallCntWidth = 32;

endpackage

// File: rtl/tcdm_stream_reader_fifo.sv
// -----------------------------------------------------------------------------
// fifo_v3
// Response buffer with the common_cells fifo_v3 interface.
// Synchronous active-low reset, registered read port when FALL_THROUGH = 0.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   flush_i       : drop all entries
//   full_o/empty_o: occupancy flags
//   usage_o       : entry count modulo DEPTH (0 when full)
//   data_i/push_i : write port
//   data_o/pop_i  : read port (head of queue)
// -----------------------------------------------------------------------------
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    logic [ADDR_DEPTH-1:0] r_rd_ptr;
    logic [ADDR_DEPTH-1:0] r_wr_ptr;
    logic [ADDR_DEPTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_empty_mem;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign w_empty_mem = (r_count == '0);
    // Fall-through on an empty queue hands the write data straight to the reader.
    assign w_bypass    = FALL_THROUGH && w_empty_mem && push_i && pop_i;

    assign full_o  = (r_count == (ADDR_DEPTH+1)'(DEPTH));
    assign empty_o = w_empty_mem && !(FALL_THROUGH && push_i);
    assign usage_o = r_count[ADDR_DEPTH-1:0];
    assign data_o  = (FALL_THROUGH && w_empty_mem) ? data_i : r_mem[r_rd_ptr];

    assign w_push = push_i && !full_o && !w_bypass;
    assign w_pop  = pop_i && !w_empty_mem;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == ADDR_DEPTH'(DEPTH - 1)) ? '0 : r_wr_ptr + ADDR_DEPTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == ADDR_DEPTH'(DEPTH - 1)) ? '0 : r_rd_ptr + ADDR_DEPTH'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (ADDR_DEPTH+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (ADDR_DEPTH+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/tcdm_stream_reader.sv
// -----------------------------------------------------------------------------
// tcdm_stream_reader
// Read-only TCDM initiator: fetches len 64-bit words at base + k*stride and
// presents them as a valid/ready stream. Requests are only issued while the
// in-flight count plus buffered responses leaves a free FIFO slot, so a
// stalled consumer can never cause a response to be dropped.
//
// Ports
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   start_i, base_i,
//   stride_i, len_i          : transfer launch (sampled in IDLE only)
//   busy_o, done_o, err_o    : status (done is a pulse, err is sticky)
//   tcdm_req_*_o             : TCDM request fields (read-only, full strobe)
//   tcdm_rsp_q_ready_i       : request grant
//   tcdm_rsp_p_valid_i/data_i: in-order read response
//   out_valid_o/ready_i/data_o: output stream
//   perf_stall_o             : cycles with request valid but not granted
//
// Build option: TCDM_STREAM_READER_PERF_EN enables the stall counter;
// without it perf_stall_o is tied to zero.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start_i; done_o pulses in the cycle after exit
// RUN   | issuing requests, gated by issued < len and FIFO credit
// DRAIN | all requests issued; waiting for responses and FIFO to empty
// -----------------------------------------------------------------------------
module tcdm_stream_reader
    import tcdm_stream_reader_pkg::*;
#(
    parameter int unsigned NarrowDataWidth = 64,
    parameter int unsigned TCDMAddrWidth   = 17,
    parameter int unsigned LenWidth        = 16,
    parameter int unsigned FifoDepth       = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [TCDMAddrWidth-1:0]     base_i,
    input  logic [TCDMAddrWidth-1:0]     stride_i,
    input  logic [LenWidth-1:0]          len_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic                         tcdm_req_write_o,
    output logic [TCDMAddrWidth-1:0]     tcdm_req_addr_o,
    output logic [3:0]                   tcdm_req_amo_o,
    output logic [NarrowDataWidth-1:0]   tcdm_req_data_o,
    output logic [4:0]                   tcdm_req_user_core_id_o,
    output logic                         tcdm_req_user_is_core_o,
    output logic [NarrowDataWidth/8-1:0] tcdm_req_strb_o,
    output logic                         tcdm_req_q_valid_o,
    input  logic                         tcdm_rsp_q_ready_i,
    input  logic                         tcdm_rsp_p_valid_i,
    input  logic [NarrowDataWidth-1:0]   tcdm_rsp_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [NarrowDataWidth-1:0]   out_data_o,
    output logic [StallCntWidth-1:0]     perf_stall_o
);

    localparam int unsigned PtrWidth = $clog2(FifoDepth);
    localparam int unsigned CntWidth = PtrWidth + 1;

    rd_state_e                r_state;
    rd_state_e                w_state_next;
    logic [TCDMAddrWidth-1:0] r_addr;
    logic [TCDMAddrWidth-1:0] r_stride;
    logic [LenWidth-1:0]      r_len;
    logic [LenWidth-1:0]      r_issued;
    logic [CntWidth-1:0]      r_outstanding;
    logic                     r_done;
    logic                     r_err;

    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [PtrWidth-1:0]      w_fifo_usage;
    logic [CntWidth-1:0]      w_fifo_count;
    logic [CntWidth:0]        w_credit_used;
    logic                     w_has_credit;
    logic                     w_req_valid;
    logic                     w_req_hs;
    logic                     w_rsp_ok;
    logic                     w_rsp_orphan;
    logic                     w_start;
    logic                     w_start_run;
    logic                     w_done_next;
    logic                     w_pop;

    // usage wraps to 0 when full; prepending the full flag restores the count.
    assign w_fifo_count  = {w_fifo_full, w_fifo_usage};
    assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign w_has_credit  = (w_credit_used < (CntWidth+1)'(FifoDepth));

    assign w_start      = (r_state == IDLE) && start_i;
    assign w_start_run  = w_start && (len_i != '0);
    assign w_req_hs     = w_req_valid && tcdm_rsp_q_ready_i;
    assign w_rsp_ok     = tcdm_rsp_p_valid_i && (r_outstanding != '0);
    assign w_rsp_orphan = tcdm_rsp_p_valid_i && (r_outstanding == '0);
    assign w_pop        = out_valid_o && out_ready_i;

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        w_req_valid  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        w_state_next = RUN;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                // Credit only shrinks through a grant, so valid holds until granted.
                w_req_valid = (r_issued < r_len) && w_has_credit;
                if (w_req_valid && tcdm_rsp_q_ready_i &&
                    ((r_issued + LenWidth'(1)) == r_len)) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((r_outstanding == '0) && w_fifo_empty) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_addr        <= '0;
            r_stride      <= '0;
            r_len         <= '0;
            r_issued      <= '0;
            r_outstanding <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;

            if (w_start_run) begin
                r_addr   <= base_i;
                r_stride <= stride_i;
                r_len    <= len_i;
                r_issued <= '0;
            end else if (w_req_hs) begin
                r_addr   <= r_addr + r_stride;
                r_issued <= r_issued + LenWidth'(1);
            end

            if (w_start) begin
                r_outstanding <= '0;
            end else if (w_req_hs && !w_rsp_ok) begin
                r_outstanding <= r_outstanding + CntWidth'(1);
            end else if (!w_req_hs && w_rsp_ok) begin
                r_outstanding <= r_outstanding - CntWidth'(1);
            end

            if (w_rsp_orphan) begin
                r_err <= 1'b1;
            end else if (w_start) begin
                r_err <= 1'b0;
            end
        end
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (NarrowDataWidth),
        .DEPTH        (FifoDepth)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .usage_o (w_fifo_usage),
        .data_i  (tcdm_rsp_data_i),
        .push_i  (w_rsp_ok),
        .data_o  (out_data_o),
        .pop_i   (w_pop)
    );

`ifdef TCDM_STREAM_READER_PERF_EN
    logic [StallCntWidth-1:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (w_start) begin
            r_stall_cnt <= '0;
        end else if (w_req_valid && !tcdm_rsp_q_ready_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + StallCntWidth'(1);
        end
    end

    assign perf_stall_o = r_stall_cnt;
`else
    assign perf_stall_o = '0;
`endif

    assign busy_o                  = (r_state != IDLE);
    assign done_o                  = r_done;
    assign err_o                   = r_err;
    assign out_valid_o             = !w_fifo_empty;
    assign tcdm_req_q_valid_o      = w_req_valid;
    assign tcdm_req_addr_o         = r_addr;
    assign tcdm_req_write_o        = 1'b0;
    assign tcdm_req_amo_o          = AmoNone;
    assign tcdm_req_data_o         = '0;
    assign tcdm_req_user_core_id_o = '0;
    assign tcdm_req_user_is_core_o = 1'b0;
    assign tcdm_req_strb_o         = '1;

endmodule
